hack_loader: RTL
================

Name: hack_loader

Overview:
- Boot/program sequencer for the Hack CPU.
- Receives a framed byte stream (from the UART receiver) and writes 16-bit instruction words into the instruction ROM's write port.
- Holds the CPU in reset while loading, and releases it only after the checksum matches.
- Sits between the UART RX, the instruction ROM and the cpu reset input.

Parameters:
- ADDR_W, 15, ROM address width. Maximum word count is 2^ADDR_W.
- TIMEOUT, 32'd1000000, idle clock cycles allowed between bytes inside a frame before the frame is aborted.
- BOOT_RUN, 1'b0, run behaviour after reset. 1 = ROM is preinitialised, so the CPU is released after reset without a load. 0 = the CPU waits for a load.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- rx_data  in  8  received byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader can accept a byte
- rom_addr  out  ADDR_W  ROM write address
- rom_data  out  16  ROM write data
- rom_we  out  1  ROM write strobe, one cycle per word
- cpu_reset  out  1  drives the cpu reset input, active high
- busy  out  1  a frame is in progress
- done  out  1  last load succeeded; CPU running
- error  out  1  last frame failed; sticky until the next sync byte

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-low.
  - While reset_n=0: state=IDLE, rom_we=0, rom_addr=0, rom_data=0, cpu_reset=1, busy=0, done=0, error=0, rx_ready=0.
  - Reset during a load abandons the frame. Words already written stay in ROM.
  - On the first clk edge after reset_n rises: rx_ready=1. If BOOT_RUN=1, go to RUN with cpu_reset=0.
- Byte transfer:
  - A byte is accepted on a clk edge where rx_valid & rx_ready.
  - rx_ready=1 in every state except CHECK, where it is 0 for exactly one cycle.
- Frame format: 0xA5 sync, LEN_HI, LEN_LO, then 2*LEN payload bytes (MSB first per word), then a CHK byte. CHK = XOR of all payload bytes.
- States:
  - IDLE / RUN:
    - In IDLE, all bytes other than 0xA5 are dropped.
    - In RUN, accepting 0xA5 re-enters loading: go to LEN_HI and assert cpu_reset=1 on the same edge.
    - In IDLE, accepting 0xA5 goes to LEN_HI.
    - In both cases: error:=0, done:=0, busy:=1, XOR accumulator:=0, word index:=0.
  - LEN_HI: store the byte as length[15:8].
  - LEN_LO: store the byte as length[7:0]. Then:
    - LEN=0 or LEN>2^ADDR_W: go to IDLE with error=1.
    - Otherwise go to DATA_HI.
  - DATA_HI: latch the byte as the word high byte and XOR it into the accumulator.
  - DATA_LO: on accept, the next cycle has:
    - rom_data={hi,byte}
    - rom_addr=index
    - rom_we=1 for one cycle
    - index increments after the write.
    - When index+1 == LEN, go to CHK_WAIT; otherwise go to DATA_HI.
  - CHK_WAIT: compare the accepted byte with the accumulator, then go to CHECK.
  - CHECK (1 cycle):
    - Match: RUN, cpu_reset=0, done=1, busy=0.
    - Mismatch: IDLE, error=1, busy=0, cpu_reset stays 1.
- Timeout: in LEN_HI through CHK_WAIT, a free counter resets on every accepted byte. When it reaches TIMEOUT, go to IDLE with error=1 and busy=0.
- Sync byte inside a frame: 0xA5 inside a frame is ordinary data, not resync.
- Output rules:
  - cpu_reset=1 in every state except RUN.
  - rom_we never asserts outside DATA_LO+1.
  - rom_addr holds its last value when idle.
- Index width: ADDR_W+1 bits, so LEN=2^ADDR_W completes without wrap.

Test Plan:
- Load of 2 words:
  - Stimulus: bytes A5 00 02 30 39 EC 10, then CHK=0x30^0x39^0xEC^0x10=0xF5.
  - Expect: rom_we pulses at addr 0 data 0x3039 and addr 1 data 0xEC10.
  - Then, one cycle after CHECK: done=1, cpu_reset=0, busy=0, error=0.
- Bad checksum:
  - Stimulus: same frame with CHK=0x00.
  - Expect: both words written, error=1, done=0, cpu_reset stays 1, state IDLE.
  - Then a correct frame: error clears on its sync, done=1.
- Zero / oversized length:
  - Stimulus: A5 00 00, and A5 80 01 with ADDR_W=15.
  - Expect: error=1 immediately after LEN_LO, no rom_we, cpu_reset=1.
- Timeout:
  - Stimulus: TIMEOUT=16; send A5 00 01 30, then idle 16 cycles.
  - Expect: error=1, busy=0, no rom_we.
  - Then a subsequent full frame loads normally.
- Reload while running:
  - Stimulus: after a successful load, send A5.
  - Expect: cpu_reset=1 on the accept edge, done=0, busy=1.
  - Then a 1-word frame (0x7FFF, CHK=0x80) writes addr 0 and releases the CPU.
- Reset mid-frame, and BOOT_RUN:
  - Stimulus: pull reset_n low after 3 payload bytes.
  - Expect: all outputs at reset values asynchronously; state IDLE on release.
  - With BOOT_RUN=1: cpu_reset=0 one edge after reset_n rises.

Source files
------------

// File: rtl/hack_loader.sv
// hack_loader: boot sequencer that loads framed UART bytes into instruction ROM and gates CPU reset
// Ports: clk/reset_n clock and async active-low reset; rx_data/rx_valid/rx_ready byte handshake;
// rom_addr/rom_data/rom_we ROM write port; cpu_reset held high until a load verifies;
// busy frame in progress; done last load verified; error last frame failed (sticky until sync).
module hack_loader #(
  parameter int          ADDR_W   = 15,
  parameter logic [31:0] TIMEOUT  = 32'd1000000,
  parameter logic        BOOT_RUN = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [15:0]       rom_data,
  output logic              rom_we,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);
  typedef enum logic [2:0] {IDLE, RUN, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHK_WAIT, CHECK} state_t;
  localparam logic [16:0] MAX_LEN = 17'(1) << ADDR_W;
  state_t state_q, state_d;
  logic [15:0] len_q, len_d, data_q, data_d;
  logic [7:0] hi_q, hi_d, xacc_q, xacc_d;
  logic [ADDR_W:0] idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0] tmo_q, tmo_d;
  logic we_q, we_d, cpu_q, cpu_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic rdy_q, rdy_d, ok_q, ok_d, boot_q, boot_d, take, frame;
  always_comb begin
    take = rx_valid & rdy_q;
    frame = state_q inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHK_WAIT};
    state_d = state_q;
    len_d = len_q;
    data_d = data_q;
    hi_d = hi_q;
    xacc_d = xacc_q;
    idx_d = idx_q;
    addr_d = addr_q;
    busy_d = busy_q;
    done_d = done_q;
    err_d = err_q;
    ok_d = ok_q;
    we_d = 1'b0;
    boot_d = 1'b0;
    tmo_d = (frame && !take) ? tmo_q + 32'd1 : 32'd0;
    case (state_q)
      IDLE, RUN: begin
        if (take && rx_data == 8'hA5) begin
          state_d = LEN_HI;
          err_d = 1'b0;
          done_d = 1'b0;
          busy_d = 1'b1;
          xacc_d = 8'h00;
          idx_d = '0;
        end else if (state_q == IDLE && boot_q && BOOT_RUN) state_d = RUN;
      end
      LEN_HI: if (take) begin
        len_d = {rx_data, len_q[7:0]};
        state_d = LEN_LO;
      end
      LEN_LO: if (take) begin
        len_d = {len_q[15:8], rx_data};
        state_d = DATA_HI;
        if (len_d == 16'd0 || {1'b0, len_d} > MAX_LEN) begin
          state_d = IDLE;
          err_d = 1'b1;
          busy_d = 1'b0;
        end
      end
      DATA_HI: if (take) begin
        hi_d = rx_data;
        xacc_d = xacc_q ^ rx_data;
        state_d = DATA_LO;
      end
      DATA_LO: if (take) begin
        we_d = 1'b1;
        addr_d = idx_q[ADDR_W-1:0];
        data_d = {hi_q, rx_data};
        xacc_d = xacc_q ^ rx_data;
        idx_d = idx_q + (ADDR_W+1)'(1);
        state_d = (17'(idx_q) + 17'd1 == {1'b0, len_q}) ? CHK_WAIT : DATA_HI;
      end
      CHK_WAIT: if (take) begin
        ok_d = rx_data == xacc_q;
        state_d = CHECK;
      end
      CHECK: begin
        state_d = ok_q ? RUN : IDLE;
        done_d = ok_q;
        err_d = !ok_q;
        busy_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    // Stalled frame: counter counts cycles since the last accepted byte.
    if (frame && !take && tmo_q + 32'd1 >= TIMEOUT) begin
      state_d = IDLE;
      err_d = 1'b1;
      busy_d = 1'b0;
    end
    rdy_d = state_d != CHECK;
    cpu_d = state_d != RUN;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      len_q <= '0;
      data_q <= '0;
      hi_q <= '0;
      xacc_q <= '0;
      idx_q <= '0;
      addr_q <= '0;
      tmo_q <= '0;
      we_q <= 1'b0;
      cpu_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      rdy_q <= 1'b0;
      ok_q <= 1'b0;
      boot_q <= 1'b1;
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      data_q <= data_d;
      hi_q <= hi_d;
      xacc_q <= xacc_d;
      idx_q <= idx_d;
      addr_q <= addr_d;
      tmo_q <= tmo_d;
      we_q <= we_d;
      cpu_q <= cpu_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
      rdy_q <= rdy_d;
      ok_q <= ok_d;
      boot_q <= boot_d;
    end
  end
  assign rx_ready = rdy_q;
  assign rom_addr = addr_q;
  assign rom_data = data_q;
  assign rom_we = we_q;
  assign cpu_reset = cpu_q;
  assign busy = busy_q;
  assign done = done_q;
  assign error = err_q;
endmodule
